// File: rtl/snes_pad_pkg.sv
// Shared button indices and helper types for the SNES pad serializer.
// Bit order matches the serial stream, LSB shifted out first.
package snes_pad_pkg;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;
    localparam int BTN_COUNT  = 12;

    typedef logic [BTN_COUNT-1:0] btn_vec_t;

endpackage

// File: rtl/pad_debounce.sv
// One button: two-flop synchroniser followed by a stable-time debouncer.
// The accepted state flips DEBOUNCE_CYCLES cycles after a stable change.
module pad_debounce #(
    parameter int DEBOUNCE_CYCLES = 65535
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic pressed_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        if (s2_q != state_q) begin
            if (cnt_q == TERM) begin
                state_d = ~state_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_i;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pressed_o = state_q;

endmodule

// File: rtl/snes_pad_serializer.sv
// Multi-pad SNES joypad serializer: debounced buttons, strobe-driven
// autofire and one active-low serial shifter per controller port.
module snes_pad_serializer
    import snes_pad_pkg::*;
#(
    parameter int N_PADS           = 2,
    parameter int PAD_BITS         = 16,
    parameter int DEBOUNCE_CYCLES  = 65535,
    parameter int AUTOFIRE_STROBES = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_PADS*BTN_COUNT-1:0]   btn_in,
    input  logic [N_PADS*BTN_COUNT-1:0]   autofire_en,
    input  logic                          joy_strb,
    input  logic [N_PADS-1:0]             joy_clk,
    output logic [N_PADS-1:0]             joy_di,
    output logic [N_PADS*BTN_COUNT-1:0]   pressed
);

    localparam int NB = N_PADS * BTN_COUNT;
    localparam int AW = $clog2(AUTOFIRE_STROBES + 1);
    localparam logic [AW-1:0] AF_TERM = AW'(AUTOFIRE_STROBES - 1);

    logic [NB-1:0]       eff;
    logic                strb_q;
    logic                strb_fall;
    logic [N_PADS-1:0]   jclk_q;
    logic [N_PADS-1:0]   rise;
    logic [AW-1:0]       af_cnt_q, af_cnt_d;
    logic                af_phase_q, af_phase_d;
    logic [PAD_BITS-1:0] sh_q [N_PADS];
    logic [PAD_BITS-1:0] sh_d [N_PADS];

    for (genvar g = 0; g < NB; g++) begin : g_db
        pad_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset_n  (reset_n),
            .btn_i    (btn_in[g]),
            .pressed_o(pressed[g])
        );
    end

    assign eff       = pressed & ~(autofire_en & {NB{af_phase_q}});
    assign strb_fall = strb_q & ~joy_strb;
    assign rise      = joy_clk & ~jclk_q;

    always_comb begin
        af_cnt_d   = af_cnt_q;
        af_phase_d = af_phase_q;
        if (strb_fall) begin
            if (af_cnt_q == AF_TERM) begin
                af_cnt_d   = '0;
                af_phase_d = ~af_phase_q;
            end else begin
                af_cnt_d = af_cnt_q + AW'(1);
            end
        end
    end

    // Strobe has priority: a clock edge during latch is dropped.
    always_comb begin
        for (int p = 0; p < N_PADS; p++) begin
            sh_d[p] = sh_q[p];
            if (joy_strb) begin
                sh_d[p] = '1;
                sh_d[p][BTN_COUNT-1:0] = ~eff[p*BTN_COUNT +: BTN_COUNT];
            end else if (rise[p]) begin
                sh_d[p] = {1'b0, sh_q[p][PAD_BITS-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q     <= 1'b0;
            jclk_q     <= '0;
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
            for (int p = 0; p < N_PADS; p++) begin
                sh_q[p] <= '1;
            end
        end else begin
            strb_q     <= joy_strb;
            jclk_q     <= joy_clk;
            af_cnt_q   <= af_cnt_d;
            af_phase_q <= af_phase_d;
            for (int p = 0; p < N_PADS; p++) begin
                sh_q[p] <= sh_d[p];
            end
        end
    end

    always_comb begin
        for (int p = 0; p < N_PADS; p++) begin
            joy_di[p] = sh_q[p][0];
        end
    end

endmodule

// File: tb/tb_snes_pad_serializer.sv
// Directed bench for snes_pad_serializer with short debounce and autofire.
module tb_snes_pad_serializer;

    localparam int NP  = 2;
    localparam int PB  = 16;
    localparam int DB  = 8;
    localparam int AF  = 2;
    localparam int NB  = NP * 12;

    logic          clk;
    logic          reset_n;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] autofire_en;
    logic          joy_strb;
    logic [NP-1:0] joy_clk;
    logic [NP-1:0] joy_di;
    logic [NB-1:0] pressed;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [PB-1:0] word;
    logic [7:0]    af_seq;

    snes_pad_serializer #(
        .N_PADS          (NP),
        .PAD_BITS        (PB),
        .DEBOUNCE_CYCLES (DB),
        .AUTOFIRE_STROBES(AF)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn_in),
        .autofire_en(autofire_en),
        .joy_strb   (joy_strb),
        .joy_clk    (joy_clk),
        .joy_di     (joy_di),
        .pressed    (pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic strobe();
        joy_strb = 1'b1;
        tick(1);
        joy_strb = 1'b0;
        tick(1);
    endtask

    task automatic read_bits(input int p, input int n,
                             output logic [PB-1:0] w);
        w = '1;
        for (int i = 0; i < n; i++) begin
            w[i] = joy_di[p];
            joy_clk[p] = 1'b1;
            tick(1);
            joy_clk[p] = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        btn_in      = '0;
        autofire_en = '0;
        joy_strb    = 1'b0;
        joy_clk     = '0;
        tick(3);
        chk("reset_joy_di", 32'(joy_di), 32'h3);
        chk("reset_pressed", 32'(pressed), 32'h0);
        reset_n = 1'b1;
        tick(2);

        // idle pad reads all ones, then zeros
        strobe();
        read_bits(0, PB, word);
        chk("idle_word", 32'(word), 32'hFFFF);
        chk("idle_tail", 32'(joy_di[0]), 32'h0);
        chk("idle_pressed", 32'(pressed), 32'h0);

        // START on pad 0: latency 2 sync + 8 debounce
        btn_in[3] = 1'b1;
        tick(9);
        chk("start_early", 32'(pressed), 32'h0);
        tick(1);
        chk("start_on_time", 32'(pressed), 32'h8);
        tick(10);
        strobe();
        read_bits(0, PB, word);
        chk("start_word", 32'(word), 32'hFFF7);
        chk("start_tail", 32'(joy_di[0]), 32'h0);

        // short glitch on pad 1 UP is rejected
        btn_in[16] = 1'b1;
        tick(5);
        btn_in[16] = 1'b0;
        tick(15);
        chk("glitch_pressed", 32'(pressed), 32'h8);
        strobe();
        read_bits(1, PB, word);
        chk("glitch_p1_word", 32'(word), 32'hFFFF);
        read_bits(0, PB, word);
        chk("glitch_p0_word", 32'(word), 32'hFFF7);

        btn_in[3] = 1'b0;
        tick(12);
        chk("start_release", 32'(pressed), 32'h0);

        // autofire on B from a clean reset
        autofire_en[0] = 1'b1;
        btn_in[0]      = 1'b1;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        tick(12);
        chk("af_pressed", 32'(pressed), 32'h1);
        for (int f = 0; f < 8; f++) begin
            strobe();
            af_seq[f] = joy_di[0];
            tick(2);
        end
        chk("af_sequence", 32'(af_seq), 32'hCC);
        autofire_en = '0;
        btn_in      = '0;
        tick(12);

        // strobe coinciding with clock edge: load wins
        btn_in[1] = 1'b1;
        tick(12);
        joy_strb   = 1'b1;
        joy_clk[0] = 1'b1;
        tick(1);
        joy_strb = 1'b0;
        tick(1);
        chk("coinc_first_b", 32'(joy_di[0]), 32'h1);
        joy_clk[0] = 1'b0;
        tick(1);
        read_bits(0, PB, word);
        chk("coinc_word", 32'(word), 32'hFFFD);

        // reset mid-transfer aborts the word
        strobe();
        read_bits(0, 5, word);
        chk("abort_partial", 32'(word[4:0]), 32'h1D);
        reset_n = 1'b0;
        tick(1);
        chk("abort_joy_di", 32'(joy_di), 32'h3);
        chk("abort_pressed", 32'(pressed), 32'h0);
        reset_n = 1'b1;
        tick(12);
        strobe();
        read_bits(0, PB, word);
        chk("abort_word", 32'(word), 32'hFFFD);
        chk("abort_tail", 32'(joy_di[0]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fail);
        $finish;
    end

endmodule
